mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 16, max cycles mem_req stays unacknowledged before timeout.
REQ-002 SHALL have port CLK  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have port RST_X  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in_valid in 1 and in_ready out 1, upstream handshake; transfer when both are high on a CLK edge.
REQ-005 SHALL have ports load, store, we_reg, halt_in, each in 1, the instruction class flags from the execute stage.
REQ-006 SHALL have ports funct3 in 3 (access size/sign), addr in 32 (ALU result), store_data in 32, alu_data in 32 (non-load writeback value), rd_in in 5.
REQ-007 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32 (word-aligned), mem_wdata out 32, mem_wstrb out 4, mem_ack in 1, mem_rdata in 32.
REQ-008 SHALL have ports wb_valid out 1, wb_we out 1, wb_rd out 5, wb_data out 32, halt_out out 1, fault out 1.

Function
REQ-009 SHALL implement states IDLE, ACCESS, HALTED; in_ready=1 only in IDLE.
REQ-010 SHALL register every accepted input; the memory request SHALL use registered values only.
REQ-011 Accepted non-memory, non-halt op SHALL give wb_valid=1 next cycle, wb_we=we_reg, wb_data=alu_data, wb_rd=rd_in; state stays IDLE.
REQ-012 Accepted load/store SHALL enter ACCESS next cycle with mem_req=1, mem_we=store, mem_addr={addr[31:2],2'b00}.
REQ-013 mem_req and all mem_* outputs SHALL stay stable in ACCESS until the cycle mem_ack=1 is sampled.
REQ-014 On mem_ack in ACCESS: next cycle mem_req=0, wb_valid=1 for one cycle, state IDLE; load gives wb_we=we_reg, store gives wb_we=0.
REQ-015 Store strobes: funct3 000 -> 4'b0001<<addr[1:0]; 001 -> 4'b0011<<{addr[1],1'b0}; other -> 4'b1111.
REQ-016 Store data SHALL be lane-replicated: byte x4, halfword x2, word as is.
REQ-017 Load data: shift mem_rdata right by 8*addr[1:0]; 000 LB sign-extend 8, 001 LH sign-extend 16, 100 LBU, 101 LHU zero-extend, other funct3 word.
REQ-018 Cycle counter SHALL count ACCESS cycles; on WAIT_MAX without ack: mem_req=0, wb_valid=1, wb_we=0, fault=1 for one cycle, then IDLE.
REQ-019 mem_ack in the same cycle the counter reaches WAIT_MAX SHALL win: normal completion, no fault.
REQ-020 mem_ack sampled outside ACCESS SHALL be ignored.
REQ-021 Accepted halt_in SHALL give wb_valid=1, halt_out=1 for one cycle next cycle, then HALTED with in_ready=0 until reset.
REQ-022 wb_valid SHALL be a single-cycle pulse per accepted instruction; fault and halt_out SHALL be 0 whenever wb_valid=0.

Reset
REQ-023 RST_X low SHALL immediately force state IDLE, counter 0, and all outputs 0 except in_ready (1 after release).
REQ-024 Reset during ACCESS SHALL abandon the transaction with no writeback; a later stale ack SHALL be ignored.

Configuration
REQ-025 Macro MISALIGN_CHECK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL issue no mem_req and give wb_valid=1, wb_we=0, fault=1 next cycle.
REQ-026 Macro MISALIGN_CHECK_EN undefined: no check; lanes follow REQ-015/017 with addr[0] ignored for halfword and addr[1:0] ignored for word.

Verification
REQ-027 OP, alu_data=0x0000_0005, rd_in=3, we_reg=1 -> next cycle wb_valid=1, wb_rd=3, wb_data=5, no mem_req.
REQ-028 SB addr=0x102, store_data=0xAB, ack after 3 cycles -> mem_addr=0x100, mem_wstrb=4'b0100, mem_wdata=0xABABABAB, wb_we=0.
REQ-029 LB addr=0x203, mem_rdata=0x80FF_FFFF -> wb_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
REQ-030 Load, no ack, WAIT_MAX=16 -> mem_req deasserts after 16 ACCESS cycles, fault=1 pulse; ack on cycle 16 -> no fault.
REQ-031 RST_X low mid-ACCESS, then ack -> mem_req=0 immediately, no wb_valid; with MISALIGN_CHECK_EN, LW addr=0x6 -> fault=1, no mem_req.

Source files
------------

// File: rtl/mem_access.sv
// mem_access: memory stage between execute and writeback.
// Accepts one instruction at a time. ALU ops and halts write back on the
// next cycle. Loads and stores go out as one registered memory request
// that is held stable until acked, or until WAIT_MAX cycles pass, which
// ends it with a fault.
// Optional feature: define MISALIGN_CHECK_EN to reject misaligned halfword
// and word accesses with a fault, without issuing a memory request.
module mem_access #(
  parameter int WAIT_MAX = 16
) (
  input  logic        CLK,
  input  logic        RST_X,
  // Handshake: an instruction transfers on a rising CLK edge where both
  // in_valid and in_ready are high. in_ready is high only in IDLE. The
  // memory side holds mem_req and every mem_* output steady until the
  // first edge where mem_ack is sampled high.
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        load,
  input  logic        store,
  input  logic        we_reg,
  input  logic        halt_in,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] alu_data,
  input  logic [4:0]  rd_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        halt_out,
  output logic        fault,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

  // Access size. Stores use only 000/001 as sub-word; loads treat the
  // unsigned variants (100/101) as sub-word as well.
  function automatic logic [1:0] size_of(input logic st, input logic [2:0] f3);
    if (st) begin
      if (f3 == 3'b000)      size_of = SZ_BYTE;
      else if (f3 == 3'b001) size_of = SZ_HALF;
      else                   size_of = SZ_WORD;
    end else begin
      if (f3[1:0] == 2'b00)      size_of = SZ_BYTE;
      else if (f3[1:0] == 2'b01) size_of = SZ_HALF;
      else                       size_of = SZ_WORD;
    end
  endfunction

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          r_store, r_we;
  logic [2:0]    r_funct3;
  logic [31:0]   r_addr, r_store_data;
  logic [4:0]    r_rd;

  logic [1:0]    r_size;
  logic [1:0]    lane_ofs;
  logic [3:0]    strb;
  logic [31:0]   shifted;
  logic [31:0]   load_data;
  logic          in_misalign;

`ifdef MISALIGN_CHECK_EN
  logic [1:0] in_size;
  assign in_size     = size_of(store, funct3);
  assign in_misalign = (load | store) &&
                       (((in_size == SZ_HALF) && addr[0]) ||
                        ((in_size == SZ_WORD) && (addr[1:0] != 2'b00)));
`else
  assign in_misalign = 1'b0;
`endif

  assign state_dbg = state;
  assign in_ready  = (state == IDLE) && RST_X;
  assign mem_req   = (state == ACCESS);
  assign mem_we    = mem_req & r_store;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign mem_wstrb = mem_we ? strb : 4'b0000;

  // Lane selection, store replication and load extraction from the
  // registered instruction. Sub-word offsets drop the address bits that
  // do not apply to the access size.
  always_comb begin
    r_size   = size_of(r_store, r_funct3);
    lane_ofs = 2'b00;
    strb     = 4'b1111;
    mem_wdata = r_store_data;
    if (r_size == SZ_BYTE) begin
      lane_ofs  = r_addr[1:0];
      strb      = 4'b0001 << lane_ofs;
      mem_wdata = {4{r_store_data[7:0]}};
    end else if (r_size == SZ_HALF) begin
      lane_ofs  = {r_addr[1], 1'b0};
      strb      = 4'b0011 << lane_ofs;
      mem_wdata = {2{r_store_data[15:0]}};
    end
    shifted = mem_rdata >> {lane_ofs, 3'b000};
    case (r_funct3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Instruction capture, state machine, wait counter and writeback pulse.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state        <= IDLE;
      cnt          <= '0;
      r_store      <= 1'b0;
      r_we         <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr       <= 32'd0;
      r_store_data <= 32'd0;
      r_rd         <= 5'd0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      halt_out     <= 1'b0;
      fault        <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      halt_out <= 1'b0;
      fault    <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            r_store      <= store;
            r_we         <= we_reg;
            r_funct3     <= funct3;
            r_addr       <= addr;
            r_store_data <= store_data;
            r_rd         <= rd_in;
            cnt          <= '0;
            wb_rd        <= rd_in;
            if (halt_in) begin
              wb_valid <= 1'b1;
              halt_out <= 1'b1;
              wb_data  <= alu_data;
              state    <= HALTED;
            end else if (load | store) begin
              if (in_misalign) begin
                wb_valid <= 1'b1;
                fault    <= 1'b1;
              end else begin
                state <= ACCESS;
              end
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= we_reg;
              wb_data  <= alu_data;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            // An ack on the last permitted cycle still completes normally.
            state    <= IDLE;
            cnt      <= '0;
            wb_valid <= 1'b1;
            wb_we    <= r_store ? 1'b0 : r_we;
            wb_data  <= r_store ? 32'd0 : load_data;
            wb_rd    <= r_rd;
          end else if (cnt == CNT_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            wb_valid <= 1'b1;
            fault    <= 1'b1;
            wb_rd    <= r_rd;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access (default WAIT_MAX = 16).
module tb_mem_access;

  logic        CLK, RST_X;
  logic        in_valid, in_ready;
  logic        load, store, we_reg, halt_in;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data, alu_data;
  logic [4:0]  rd_in;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_we, halt_out, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  mem_access #(.WAIT_MAX(16)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .in_valid(in_valid), .in_ready(in_ready),
    .load(load), .store(store), .we_reg(we_reg), .halt_in(halt_in),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .alu_data(alu_data), .rd_in(rd_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .halt_out(halt_out), .fault(fault), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Driver: present one instruction for one edge, then return at edge+1.
  task automatic issue(input logic ld, input logic st, input logic we,
                       input logic hl, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] alu, input logic [4:0] rd);
    load = ld; store = st; we_reg = we; halt_in = hl; funct3 = f3;
    addr = a; store_data = sd; alu_data = alu; rd_in = rd;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; load = 1'b0; store = 1'b0; halt_in = 1'b0;
  endtask

  task automatic test_reset();
    RST_X = 1'b0;
    #12;
    n_vec++;
    if (in_ready !== 1'b0 || mem_req !== 1'b0 || wb_valid !== 1'b0 ||
        fault !== 1'b0 || halt_out !== 1'b0 || state_dbg !== 2'd0 ||
        mem_addr !== 32'd0 || wb_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b req=%b wbv=%b fault=%b halt=%b st=%0d addr=%h wbd=%h, want all 0",
               in_ready, mem_req, wb_valid, fault, halt_out, state_dbg, mem_addr, wb_data);
    end
    RST_X = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_op();
    issue(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0000_0005, 5'd3);
    n_vec++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'd5 ||
        wb_we !== 1'b1 || mem_req !== 1'b0 || fault !== 1'b0) begin
      n_err++;
      $display("FAIL op_wb: wbv=%b rd=%0d data=%h we=%b req=%b fault=%b, want 1 3 5 1 0 0",
               wb_valid, wb_rd, wb_data, wb_we, mem_req, fault);
    end
    @(posedge CLK); #1;
    n_vec++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL op_pulse: wbv=%b ready=%b, want 0 1", wb_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    load = 1'b0; store = 1'b0; halt_in = 1'b0; we_reg = 1'b1;
    in_valid = 1'b1; alu_data = 32'h1111_0001; rd_in = 5'd4;
    @(posedge CLK); #1;
    n_vec++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h1111_0001 || wb_rd !== 5'd4) begin
      n_err++; $display("FAIL b2b_first: wbv=%b data=%h rd=%0d, want 1 11110001 4", wb_valid, wb_data, wb_rd);
    end
    we_reg = 1'b0; alu_data = 32'h2222_0002; rd_in = 5'd5;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n_vec++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h2222_0002 || wb_rd !== 5'd5 || wb_we !== 1'b0) begin
      n_err++; $display("FAIL b2b_second: wbv=%b data=%h rd=%0d we=%b, want 1 22220002 5 0",
                        wb_valid, wb_data, wb_rd, wb_we);
    end
  endtask

  task automatic test_store(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [31:0] exp_addr,
                            input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                            input int ack_cycle);
    logic held;
    issue(1'b0, 1'b1, 1'b1, 1'b0, f3, a, sd, 32'h0, 5'd6);
    n_vec++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_addr ||
        mem_wstrb !== exp_strb || mem_wdata !== exp_wdata) begin
      n_err++;
      $display("FAIL %s_req: req=%b we=%b addr=%h strb=%b wdata=%h, want 1 1 %h %b %h",
               nm, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, exp_addr, exp_strb, exp_wdata);
    end
    held = 1'b1;
    for (int i = 1; i < ack_cycle; i++) begin
      @(posedge CLK); #1;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_wstrb !== exp_strb ||
          mem_wdata !== exp_wdata || wb_valid !== 1'b0) held = 1'b0;
    end
    n_vec++;
    if (held !== 1'b1) begin
      n_err++; $display("FAIL %s_hold: got stable=%b want 1", nm, held);
    end
    mem_ack = 1'b1;
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    n_vec++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_we !== 1'b0 || fault !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL %s_done: req=%b wbv=%b we=%b fault=%b ready=%b, want 0 1 0 0 1",
                        nm, mem_req, wb_valid, wb_we, fault, in_ready);
    end
  endtask

  task automatic test_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b1, 1'b0, 1'b1, 1'b0, f3, a, 32'h0, 32'h0, 5'd9);
    n_vec++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== {a[31:2], 2'b00}) begin
      n_err++; $display("FAIL %s_req: req=%b we=%b addr=%h, want 1 0 %h",
                        nm, mem_req, mem_we, mem_addr, {a[31:2], 2'b00});
    end
    mem_rdata = rdata; mem_ack = 1'b1;
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    n_vec++;
    if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd9 || wb_data !== exp || fault !== 1'b0) begin
      n_err++; $display("FAIL %s_wb: wbv=%b we=%b rd=%0d data=%h fault=%b, want 1 1 9 %h 0",
                        nm, wb_valid, wb_we, wb_rd, wb_data, fault, exp);
    end
  endtask

  task automatic test_ack_idle();
    mem_ack = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    n_vec++;
    if (wb_valid !== 1'b0 || mem_req !== 1'b0 || state_dbg !== 2'd0) begin
      n_err++; $display("FAIL ack_idle: wbv=%b req=%b st=%0d, want 0 0 0", wb_valid, mem_req, state_dbg);
    end
  endtask

  task automatic test_timeout();
    logic held;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, 5'd12);
    held = mem_req;
    for (int i = 1; i < 16; i++) begin
      @(posedge CLK); #1;
      if (mem_req !== 1'b1 || wb_valid !== 1'b0) held = 1'b0;
    end
    n_vec++;
    if (held !== 1'b1) begin
      n_err++; $display("FAIL timeout_wait: got held=%b want 1 over 16 cycles", held);
    end
    @(posedge CLK); #1;
    n_vec++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_we !== 1'b0 || fault !== 1'b1) begin
      n_err++; $display("FAIL timeout_fault: req=%b wbv=%b we=%b fault=%b, want 0 1 0 1",
                        mem_req, wb_valid, wb_we, fault);
    end
    @(posedge CLK); #1;
    n_vec++;
    if (fault !== 1'b0 || wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL timeout_pulse: fault=%b wbv=%b ready=%b, want 0 0 1", fault, wb_valid, in_ready);
    end
  endtask

  task automatic test_ack_last_cycle();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, 5'd13);
    for (int i = 1; i < 16; i++) begin
      @(posedge CLK); #1;
    end
    mem_rdata = 32'h1122_3344; mem_ack = 1'b1;
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    n_vec++;
    if (wb_valid !== 1'b1 || fault !== 1'b0 || wb_data !== 32'h1122_3344 || wb_we !== 1'b1) begin
      n_err++; $display("FAIL ack_last: wbv=%b fault=%b data=%h we=%b, want 1 0 11223344 1",
                        wb_valid, fault, wb_data, wb_we);
    end
  endtask

  task automatic test_reset_mid();
    logic quiet;
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h0, 5'd14);
    @(posedge CLK); #1;
    RST_X = 1'b0;
    #1;
    n_vec++;
    if (mem_req !== 1'b0 || state_dbg !== 2'd0 || wb_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: req=%b st=%0d wbv=%b ready=%b, want 0 0 0 0",
                        mem_req, state_dbg, wb_valid, in_ready);
    end
    #2;
    RST_X = 1'b1;
    mem_ack = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      if (wb_valid !== 1'b0 || mem_req !== 1'b0) quiet = 1'b0;
    end
    mem_ack = 1'b0;
    n_vec++;
    if (quiet !== 1'b1 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL stale_ack: quiet=%b ready=%b, want 1 1", quiet, in_ready);
    end
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 5'd15);
`ifdef MISALIGN_CHECK_EN
    n_vec++;
    if (mem_req !== 1'b0 || wb_valid !== 1'b1 || wb_we !== 1'b0 || fault !== 1'b1) begin
      n_err++; $display("FAIL misalign_fault: req=%b wbv=%b we=%b fault=%b, want 0 1 0 1",
                        mem_req, wb_valid, wb_we, fault);
    end
`else
    n_vec++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0004 || fault !== 1'b0) begin
      n_err++; $display("FAIL misalign_unchecked: req=%b addr=%h fault=%b, want 1 00000004 0",
                        mem_req, mem_addr, fault);
    end
    mem_rdata = 32'hA5A5_0F0F; mem_ack = 1'b1;
    @(posedge CLK); #1;
    mem_ack = 1'b0;
    n_vec++;
    if (wb_valid !== 1'b1 || wb_data !== 32'hA5A5_0F0F) begin
      n_err++; $display("FAIL misalign_word: wbv=%b data=%h, want 1 a5a50f0f", wb_valid, wb_data);
    end
`endif
  endtask

  task automatic test_halt();
    issue(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0);
    n_vec++;
    if (wb_valid !== 1'b1 || halt_out !== 1'b1 || in_ready !== 1'b0 || state_dbg !== 2'd2 || fault !== 1'b0) begin
      n_err++; $display("FAIL halt_pulse: wbv=%b halt=%b ready=%b st=%0d fault=%b, want 1 1 0 2 0",
                        wb_valid, halt_out, in_ready, state_dbg, fault);
    end
    issue(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0, 32'h0, 32'h77, 5'd1);
    n_vec++;
    if (wb_valid !== 1'b0 || halt_out !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL halted_stays: wbv=%b halt=%b ready=%b, want 0 0 0", wb_valid, halt_out, in_ready);
    end
  endtask

  // Test sequence and final report
  initial begin
    in_valid = 1'b0; load = 1'b0; store = 1'b0; we_reg = 1'b0; halt_in = 1'b0;
    funct3 = 3'd0; addr = 32'd0; store_data = 32'd0; alu_data = 32'd0; rd_in = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    test_reset();
    test_op();
    test_back_to_back();
    test_store("sb", 3'b000, 32'h0000_0102, 32'h0000_00AB, 32'h0000_0100, 4'b0100, 32'hABAB_ABAB, 3);
    test_store("sh", 3'b001, 32'h0000_0106, 32'h1234_5678, 32'h0000_0104, 4'b1100, 32'h5678_5678, 1);
    test_store("sw", 3'b010, 32'h0000_0108, 32'hCAFE_F00D, 32'h0000_0108, 4'b1111, 32'hCAFE_F00D, 2);
    test_load("lb",  3'b000, 32'h0000_0203, 32'h80FF_FFFF, 32'hFFFF_FF80);
    test_load("lbu", 3'b100, 32'h0000_0203, 32'h80FF_FFFF, 32'h0000_0080);
    test_load("lb1", 3'b000, 32'h0000_0201, 32'h0000_7F00, 32'h0000_007F);
    test_load("lh",  3'b001, 32'h0000_0202, 32'h8001_1234, 32'hFFFF_8001);
    test_load("lhu", 3'b101, 32'h0000_0202, 32'h8001_1234, 32'h0000_8001);
    test_load("lw",  3'b010, 32'h0000_0200, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    test_ack_idle();
    test_timeout();
    test_ack_last_cycle();
    test_reset_mid();
    test_misalign();
    test_halt();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
